// File: rtl/exec_result_stage.sv
// Registered ALU result stage with a two-entry (OUT + SKID) skid buffer on a valid/ready handshake.
// Define EXEC_STAGE_FLAGS_EN to generate NZCV flags with each beat; otherwise out_flags is tied to 0.
module exec_result_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] y,
   input  logic [3:0]   ALUControl,
   input  logic         carry_in,
   input  logic         overflow_in,
   input  logic [3:0]   rd_in,
   input  logic         set_flags_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [3:0]   out_flags,
   output logic [3:0]   out_rd,
   output logic         out_set_flags
);

   typedef struct packed {
      logic [N-1:0] result;
`ifdef EXEC_STAGE_FLAGS_EN
      logic [3:0]   flags;
`endif
      logic [3:0]   rd;
      logic         set_flags;
   } entry_t;

   entry_t in_entry;
   entry_t out_q;
   entry_t skid_q;
   logic   out_valid_q;
   logic   skid_valid_q;
   logic   skid_valid_next;
   logic   in_ready_q;
   logic   accept;
   logic   deliver;

   assign accept  = in_valid & in_ready_q;
   assign deliver = out_valid_q & out_ready;

   // SKID fills only when OUT is occupied and stalled; it drains whenever OUT is delivered.
   assign skid_valid_next = (accept & out_valid_q & ~out_ready) | (skid_valid_q & ~deliver);

   always_comb begin
      in_entry           = '0;
      in_entry.result    = y;
      in_entry.rd        = rd_in;
      in_entry.set_flags = set_flags_in;
`ifdef EXEC_STAGE_FLAGS_EN
      in_entry.flags[3]  = y[N-1];
      in_entry.flags[2]  = (y == '0);
      // Only add/subtract produce meaningful carry and overflow.
      if (ALUControl == 4'b0000 || ALUControl == 4'b0001) begin
         in_entry.flags[1] = carry_in;
         in_entry.flags[0] = overflow_in;
      end
`endif
   end

`ifndef EXEC_STAGE_FLAGS_EN
   logic flag_inputs_unused;
   assign flag_inputs_unused = ^{ALUControl, carry_in, overflow_in};
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: payload registers are reset too, because the outputs must read 0 while reset is held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         out_q        <= '0;
         skid_q       <= '0;
      end else begin
         skid_valid_q <= skid_valid_next;
         in_ready_q   <= ~skid_valid_next;
         if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
               out_q       <= skid_q;
               out_valid_q <= 1'b1;
            end else begin
               out_valid_q <= accept;
               if (accept) begin
                  out_q <= in_entry;
               end
            end
         end else if (accept) begin
            skid_q <= in_entry;
         end
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_result    = out_q.result;
   assign out_rd        = out_q.rd;
   assign out_set_flags = out_q.set_flags;
`ifdef EXEC_STAGE_FLAGS_EN
   assign out_flags     = out_q.flags;
`else
   assign out_flags     = 4'b0000;
`endif

endmodule
